// File: rtl/game_pkg.sv
// Shared definitions for the game timer: FSM state encoding, default timing
// constants and small saturating arithmetic helpers.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESTART = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } game_state_e;

    localparam int unsigned DEF_CLK_HZ           = 50_000_000;
    localparam int unsigned DEF_GAME_SECONDS     = 30;
    localparam int unsigned DEF_PRESTART_SECONDS = 3;

    localparam int unsigned PRESCALE_W = 32;
    localparam logic [7:0]  SCORE_MAX  = 8'd99;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= SCORE_MAX) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] dec_floor0(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled and raises a
// registered tick during the cycle the count sits at CLK_HZ-1.
module sec_prescaler
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    // CLK_HZ is expected to be at least 2 so a tick never coincides with a clear.
    localparam logic [PRESCALE_W-1:0] CNT_MAX = PRESCALE_W'(CLK_HZ - 1);
    localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;
    logic                  tick_q;
    logic                  tick_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_ONE;
        end
    end

    // Tick is registered alongside the count so it is high exactly when cnt_q == CNT_MAX.
    assign tick_d = enable && !clear && (cnt_d == CNT_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_timer_ctrl.sv
// Basketball game timer: IDLE -> PRESTART countdown -> RUN play period -> DONE,
// counting made baskets during RUN and pulsing commit once the score is final.
module game_timer_ctrl
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ           = DEF_CLK_HZ,
    parameter int unsigned GAME_SECONDS     = DEF_GAME_SECONDS,
    parameter int unsigned PRESTART_SECONDS = DEF_PRESTART_SECONDS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       shot_in,
    output logic [7:0] time_left,
    output logic [7:0] score,
    output logic       running,
    output logic       game_over,
    output logic       commit,
    output logic       sec_tick
);

    localparam logic [7:0] GAME_TL = 8'(GAME_SECONDS);
    localparam logic [7:0] PRE_TL  = 8'(PRESTART_SECONDS);

    game_state_e state_q;
    logic [7:0]  time_left_q;
    logic [7:0]  score_q;
    logic        running_q;
    logic        game_over_q;
    logic        commit_q;

    logic tick;
    logic launch;
    logic last_sec;
    logic presc_clear;
    logic presc_enable;

    assign launch       = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_sec     = tick && (time_left_q == 8'd1);
    assign presc_enable = (state_q == ST_PRESTART) || (state_q == ST_RUN);
    // Restart the second boundary both at game launch and when play begins.
    assign presc_clear  = launch || ((state_q == ST_PRESTART) && last_sec);

    sec_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_presc (
        .clock (clock),
        .reset (reset),
        .clear (presc_clear),
        .enable(presc_enable),
        .tick  (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            time_left_q <= 8'd0;
            score_q     <= 8'd0;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_PRESTART;
                        time_left_q <= PRE_TL;
                        score_q     <= 8'd0;
                        running_q   <= 1'b0;
                        game_over_q <= 1'b0;
                    end
                end
                ST_PRESTART: begin
                    if (last_sec) begin
                        state_q     <= ST_RUN;
                        time_left_q <= GAME_TL;
                        running_q   <= 1'b1;
                    end else if (tick) begin
                        time_left_q <= dec_floor0(time_left_q);
                    end
                end
                ST_RUN: begin
                    // A basket in the final tick cycle still counts; commit sees it.
                    if (shot_in) begin
                        score_q <= sat_inc(score_q);
                    end
                    if (tick) begin
                        time_left_q <= dec_floor0(time_left_q);
                    end
                    if (last_sec) begin
                        state_q     <= ST_DONE;
                        running_q   <= 1'b0;
                        game_over_q <= 1'b1;
                        commit_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign time_left = time_left_q;
    assign score     = score_q;
    assign running   = running_q;
    assign game_over = game_over_q;
    assign commit    = commit_q;
    assign sec_tick  = tick;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: two instances (short game and 99-second game)
// checked every cycle against an elapsed-cycle model, plus literal spot checks.
`timescale 1ns/1ps
module tb_game_timer_ctrl;

    localparam int C   = 10;
    localparam int P   = 3;
    localparam int G_A = 5;
    localparam int G_B = 99;

    localparam int PH_IDLE = 0;
    localparam int PH_PRE  = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, start_a, shot_a;
    logic [7:0] tl_a, sc_a;
    logic       run_a, go_a, cm_a, tk_a;
    logic       rst_b_n, start_b, shot_b;
    logic [7:0] tl_b, sc_b;
    logic       run_b, go_b, cm_b, tk_b;

    game_timer_ctrl #(.CLK_HZ(C), .GAME_SECONDS(G_A), .PRESTART_SECONDS(P)) u_dut_a (
        .clock(clk), .reset(rst_a_n), .start(start_a), .shot_in(shot_a),
        .time_left(tl_a), .score(sc_a), .running(run_a), .game_over(go_a),
        .commit(cm_a), .sec_tick(tk_a)
    );

    game_timer_ctrl #(.CLK_HZ(C), .GAME_SECONDS(G_B), .PRESTART_SECONDS(P)) u_dut_b (
        .clock(clk), .reset(rst_b_n), .start(start_b), .shot_in(shot_b),
        .time_left(tl_b), .score(sc_b), .running(run_b), .game_over(go_b),
        .commit(cm_b), .sec_tick(tk_b)
    );

    int checks   = 0;
    int failures = 0;

    // Model: phase, cycles elapsed since entering the phase, and score.
    int m_ph [2] = '{0, 0};
    int m_k  [2] = '{0, 0};
    int m_sc [2] = '{0, 0};

    function automatic int game_len(input int i);
        return (i == 0) ? G_A : G_B;
    endfunction

    task automatic model_reset(input int i);
        m_ph[i] = PH_IDLE;
        m_k[i]  = 0;
        m_sc[i] = 0;
    endtask

    task automatic model_step(input int i, input logic rn, input logic st, input logic sh);
        if (!rn) begin
            model_reset(i);
        end else begin
            case (m_ph[i])
                PH_IDLE: if (st) begin m_ph[i] = PH_PRE; m_k[i] = 0; m_sc[i] = 0; end
                PH_PRE: begin
                    if (m_k[i] == P * C - 1) begin m_ph[i] = PH_RUN; m_k[i] = 0; end
                    else m_k[i]++;
                end
                PH_RUN: begin
                    if (sh && m_sc[i] < 99) m_sc[i]++;
                    if (m_k[i] == game_len(i) * C - 1) begin m_ph[i] = PH_DONE; m_k[i] = 0; end
                    else m_k[i]++;
                end
                default: begin
                    if (st) begin m_ph[i] = PH_PRE; m_k[i] = 0; m_sc[i] = 0; end
                    else if (m_k[i] < 1000) m_k[i]++;
                end
            endcase
        end
    endtask

    // Packed {time_left, score, running, game_over, commit, sec_tick}.
    function automatic logic [19:0] model_out(input int i);
        int   tl;
        logic tick;
        tl   = 0;
        tick = 1'b0;
        if (m_ph[i] == PH_PRE) begin
            tl   = P - m_k[i] / C;
            tick = (m_k[i] % C == C - 1);
        end else if (m_ph[i] == PH_RUN) begin
            tl   = game_len(i) - m_k[i] / C;
            tick = (m_k[i] % C == C - 1);
        end
        return {8'(tl), 8'(m_sc[i]), (m_ph[i] == PH_RUN), (m_ph[i] == PH_DONE),
                (m_ph[i] == PH_DONE && m_k[i] == 0), tick};
    endfunction

    task automatic cmp_out(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got tl=%0d sc=%0d run=%b go=%b cm=%b tk=%b expected tl=%0d sc=%0d run=%b go=%b cm=%b tk=%b",
                     name, $time, act[19:12], act[11:4], act[3], act[2], act[1], act[0],
                     exp[19:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(0, rst_a_n, start_a, shot_a);
            model_step(1, rst_b_n, start_b, shot_b);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_a_n) model_reset(0);
            if (!rst_b_n) model_reset(1);
            cmp_out("dut_a_cycle", {tl_a, sc_a, run_a, go_a, cm_a, tk_a}, model_out(0));
            cmp_out("dut_b_cycle", {tl_b, sc_b, run_b, go_b, cm_b, tk_b}, model_out(1));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) nxt();
    endtask

    initial begin
        rst_a_n = 1'b0; start_a = 1'b0; shot_a = 1'b0;
        rst_b_n = 1'b0; start_b = 1'b0; shot_b = 1'b0;
        wait_cyc(3);
        check_lit("rst_time_left", tl_a, 0);
        check_lit("rst_score", sc_a, 0);
        check_lit("rst_running", run_a, 0);
        check_lit("rst_game_over", go_a, 0);
        check_lit("rst_commit", cm_a, 0);
        check_lit("rst_sec_tick", tk_a, 0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        nxt();

        // Game 1: full timing, shots in every phase
        shot_a = 1'b1; nxt(); shot_a = 1'b0; nxt();
        check_lit("idle_shot_ignored", sc_a, 0);
        start_a = 1'b1; nxt(); start_a = 1'b0;
        check_lit("pre_tl_3", tl_a, 3);
        check_lit("pre_not_running", run_a, 0);
        wait_cyc(4); shot_a = 1'b1; nxt(); shot_a = 1'b0;
        wait_cyc(3);
        check_lit("pre_no_tick_k8", tk_a, 0);
        nxt();
        check_lit("pre_tick_k9", tk_a, 1);
        nxt();
        check_lit("pre_tl_2", tl_a, 2);
        wait_cyc(10);
        check_lit("pre_tl_1", tl_a, 1);
        wait_cyc(10);
        check_lit("run_entered", run_a, 1);
        check_lit("run_tl_5", tl_a, 5);
        check_lit("pre_shot_ignored", sc_a, 0);
        for (int n = 0; n < 4; n++) begin
            wait_cyc(3); shot_a = 1'b1; nxt(); shot_a = 1'b0;
        end
        check_lit("run_score_4", sc_a, 4);
        wait_cyc(33);
        check_lit("run_last_tl_1", tl_a, 1);
        check_lit("run_last_not_over", go_a, 0);
        nxt();
        check_lit("done_game_over", go_a, 1);
        check_lit("done_commit", cm_a, 1);
        check_lit("done_commit_score", sc_a, 4);
        check_lit("done_tl_0", tl_a, 0);
        nxt();
        check_lit("done_commit_single", cm_a, 0);
        shot_a = 1'b1; nxt(); shot_a = 1'b0; nxt();
        check_lit("done_shot_ignored", sc_a, 4);

        // Game 2: restart from DONE, then boundary shots around the final tick
        start_a = 1'b1; nxt(); start_a = 1'b0;
        check_lit("restart_score_0", sc_a, 0);
        check_lit("restart_tl_3", tl_a, 3);
        check_lit("restart_game_over_0", go_a, 0);
        check_lit("restart_commit_0", cm_a, 0);
        wait_cyc(79);
        shot_a = 1'b1; nxt();
        check_lit("boundary_commit", cm_a, 1);
        check_lit("boundary_shot_counted", sc_a, 1);
        nxt(); shot_a = 1'b0;
        check_lit("boundary_late_shot_ignored", sc_a, 1);

        // Game 3: reset in the middle of RUN
        start_a = 1'b1; nxt(); start_a = 1'b0;
        wait_cyc(35);
        for (int n = 0; n < 3; n++) begin
            shot_a = 1'b1; nxt(); shot_a = 1'b0; nxt();
        end
        check_lit("midrun_score_3", sc_a, 3);
        rst_a_n = 1'b0; #1;
        check_lit("async_rst_tl", tl_a, 0);
        check_lit("async_rst_score", sc_a, 0);
        check_lit("async_rst_running", run_a, 0);
        nxt(); rst_a_n = 1'b1;
        wait_cyc(5);
        check_lit("post_rst_idle_go", go_a, 0);
        check_lit("post_rst_idle_tl", tl_a, 0);
        start_a = 1'b1; nxt(); start_a = 1'b0;
        check_lit("post_rst_start_tl_3", tl_a, 3);
        wait_cyc(85);
        check_lit("post_rst_game_over", go_a, 1);

        // Saturation on the 99-second instance
        start_b = 1'b1; nxt(); start_b = 1'b0;
        wait_cyc(30);
        check_lit("sat_run", run_b, 1);
        check_lit("sat_tl_99", tl_b, 99);
        for (int n = 0; n < 120; n++) begin
            shot_b = 1'b1; nxt(); shot_b = 1'b0; nxt();
        end
        check_lit("sat_score_99", sc_b, 99);

        // Random traffic on both instances
        for (int n = 0; n < 800; n++) begin
            start_a = ($urandom_range(0, 49) == 0);
            shot_a  = ($urandom_range(0, 2) == 0);
            rst_a_n = ($urandom_range(0, 399) != 0);
            start_b = ($urandom_range(0, 49) == 0);
            shot_b  = ($urandom_range(0, 2) == 0);
            rst_b_n = ($urandom_range(0, 399) != 0);
            nxt();
        end
        start_a = 1'b0; shot_a = 1'b0; rst_a_n = 1'b1;
        start_b = 1'b0; shot_b = 1'b0; rst_b_n = 1'b1;
        wait_cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
